// File: rtl/bf_block_fifo.sv
// Block FIFO between FFT butterfly stages: each entry is one block of LANES
// complex samples (separate real/imag arrays), stored as a circular buffer.
module bf_block_fifo #(
    parameter int WIDTH    = 9,
    parameter int LANES    = 16,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int HOLD_OUT = 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear,
    input  logic                                 write,
    input  logic                                 read,
    input  logic signed [LANES-1:0][WIDTH-1:0]   din_real,
    input  logic signed [LANES-1:0][WIDTH-1:0]   din_imag,
    output logic signed [LANES-1:0][WIDTH-1:0]   dout_real,
    output logic signed [LANES-1:0][WIDTH-1:0]   dout_imag,
    output logic                                 dout_valid,
    output logic                                 full,
    output logic                                 empty,
    output logic                                 almost_full,
    output logic [CW-1:0]                        count,
    output logic                                 overflow,
    output logic                                 underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic signed [LANES-1:0][WIDTH-1:0] mem_real [DEPTH];
    logic signed [LANES-1:0][WIDTH-1:0] mem_imag [DEPTH];

    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [PW-1:0] wp_next;
    logic [PW-1:0] rp_next;
    logic          push;
    logic          pop;

    // Occupancy flags decode the registered count directly, no extra stage.
    always_comb begin
        full        = (count == CW'(DEPTH));
        empty       = (count == '0);
        almost_full = (count >= CW'(AF_LEVEL));
    end

    // Acceptance from pre-edge state; a pop frees a slot so a push at full is legal.
    always_comb begin
        push    = write && (!full || read);
        pop     = read && !empty;
        wp_next = (wp == PW'(DEPTH - 1)) ? '0 : wp + PW'(1);
        rp_next = (rp == PW'(DEPTH - 1)) ? '0 : rp + PW'(1);
    end

    // Block storage; contents are not reset, only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_real[wp] <= din_real;
            mem_imag[wp] <= din_imag;
        end
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) wp <= wp_next;
            if (pop)  rp <= rp_next;
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            if (write && !push) overflow  <= 1'b1;
            if (read && !pop)   underflow <= 1'b1;
        end
    end

    // Registered output block; at full with push+pop the old entry is read
    // before the same slot is overwritten, since both are non-blocking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_real  <= '0;
            dout_imag  <= '0;
            dout_valid <= 1'b0;
        end else if (clear) begin
            dout_real  <= '0;
            dout_imag  <= '0;
            dout_valid <= 1'b0;
        end else if (pop) begin
            dout_real  <= mem_real[rp];
            dout_imag  <= mem_imag[rp];
            dout_valid <= 1'b1;
        end else begin
            dout_valid <= 1'b0;
            if (HOLD_OUT == 0) begin
                dout_real <= '0;
                dout_imag <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bf_block_fifo.sv
// Directed bench: one FIFO with held output, a twin with zeroed idle output.
module tb_bf_block_fifo;

    localparam int W  = 9;
    localparam int L  = 16;
    localparam int D  = 16;
    localparam int CW = $clog2(D + 1);

    typedef logic [L-1:0][W-1:0] blk_t;

    logic clk = 1'b0;
    logic rst, clear, write, read;
    blk_t din_real, din_imag;

    blk_t          dout_real, dout_imag, z_dout_real, z_dout_imag;
    logic          dout_valid, full, empty, almost_full, overflow, underflow;
    logic [CW-1:0] count;
    logic          z_dout_valid, z_full, z_empty, z_almost_full, z_overflow, z_underflow;
    logic [CW-1:0] z_count;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    bf_block_fifo #(.WIDTH(W), .LANES(L), .DEPTH(D), .AF_LEVEL(14), .HOLD_OUT(1)) dut (
        .clk(clk), .rst(rst), .clear(clear), .write(write), .read(read),
        .din_real(din_real), .din_imag(din_imag),
        .dout_real(dout_real), .dout_imag(dout_imag), .dout_valid(dout_valid),
        .full(full), .empty(empty), .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    bf_block_fifo #(.WIDTH(W), .LANES(L), .DEPTH(D), .AF_LEVEL(14), .HOLD_OUT(0)) dut_z (
        .clk(clk), .rst(rst), .clear(clear), .write(write), .read(read),
        .din_real(din_real), .din_imag(din_imag),
        .dout_real(z_dout_real), .dout_imag(z_dout_imag), .dout_valid(z_dout_valid),
        .full(z_full), .empty(z_empty), .almost_full(z_almost_full), .count(z_count),
        .overflow(z_overflow), .underflow(z_underflow)
    );

    // Block p, lane k: real = p*16+k, imag = -(p*16+k), both truncated to W bits.
    function automatic blk_t mkr(input int p);
        blk_t r;
        for (int k = 0; k < L; k++) begin
            int v;
            v = p * 16 + k;
            r[k] = v[W-1:0];
        end
        return r;
    endfunction

    function automatic blk_t mki(input int p);
        blk_t r;
        for (int k = 0; k < L; k++) begin
            int v;
            v = -(p * 16 + k);
            r[k] = v[W-1:0];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input int p);
        write    = w;
        read     = r;
        din_real = mkr(p);
        din_imag = mki(p);
        tick();
        write = 1'b0;
        read  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; write = 1'b0; read = 1'b0;
        din_real = mkr(3); din_imag = mki(3);
        tick();
        write = 1'b1;
        tick();
        tick();
        vectors++;
        if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: count=%0d empty=%b full=%b af=%b, want 0 1 0 0", count, empty, full, almost_full);
        end
        vectors++;
        if (dout_valid !== 1'b0 || dout_real !== '0 || dout_imag !== '0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_dout: valid=%b real=%h imag=%h ovf=%b udf=%b, want all 0", dout_valid, dout_real, dout_imag, overflow, underflow);
        end
        write = 1'b0;
        rst   = 1'b0;
        tick();
        vectors++;
        if (count !== '0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: count=%0d empty=%b, want 0 1", count, empty);
        end
    endtask

    task automatic test_fill_drain();
        for (int b = 0; b < D; b++) begin
            drive(1'b1, 1'b0, b);
            if (b == D - 2) begin
                vectors++;
                if (full !== 1'b0 || count !== CW'(D - 1)) begin
                    errors++;
                    $display("FAIL fill_15: full=%b count=%0d, want 0 15", full, count);
                end
            end
        end
        vectors++;
        if (full !== 1'b1 || count !== CW'(D) || empty !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: full=%b count=%0d empty=%b, want 1 16 0", full, count, empty);
        end
        for (int b = 0; b < D; b++) begin
            drive(1'b0, 1'b1, 0);
            vectors++;
            if (dout_valid !== 1'b1 || dout_real !== mkr(b) || dout_imag !== mki(b)) begin
                errors++;
                $display("FAIL drain_%0d: valid=%b real=%h imag=%h, want 1 %h %h", b, dout_valid, dout_real, dout_imag, mkr(b), mki(b));
            end
        end
        vectors++;
        if (empty !== 1'b1 || count !== '0) begin
            errors++;
            $display("FAIL drain_empty: empty=%b count=%0d, want 1 0", empty, count);
        end
    endtask

    task automatic test_hold_out();
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (dout_valid !== 1'b0 || dout_real !== mkr(D - 1) || dout_imag !== mki(D - 1)) begin
                errors++;
                $display("FAIL hold_%0d: valid=%b real=%h imag=%h, want 0 %h %h", i, dout_valid, dout_real, dout_imag, mkr(D - 1), mki(D - 1));
            end
            vectors++;
            if (z_dout_valid !== 1'b0 || z_dout_real !== '0 || z_dout_imag !== '0) begin
                errors++;
                $display("FAIL zero_idle_%0d: valid=%b real=%h imag=%h, want 0 0 0", i, z_dout_valid, z_dout_real, z_dout_imag);
            end
        end
    endtask

    task automatic test_wrap_af();
        for (int b = 0; b < 10; b++) drive(1'b1, 1'b0, b);
        for (int b = 0; b < 10; b++) drive(1'b0, 1'b1, 0);
        for (int i = 0; i < D; i++) begin
            drive(1'b1, 1'b0, 10 + i);
            vectors++;
            if (almost_full !== (i + 1 >= 14) || count !== CW'(i + 1)) begin
                errors++;
                $display("FAIL af_%0d: af=%b count=%0d, want %b %0d", i + 1, almost_full, count, (i + 1 >= 14), i + 1);
            end
        end
        for (int i = 0; i < D; i++) begin
            drive(1'b0, 1'b1, 0);
            vectors++;
            if (dout_real !== mkr(10 + i) || dout_imag !== mki(10 + i) || z_dout_real !== mkr(10 + i)) begin
                errors++;
                $display("FAIL wrap_%0d: real=%h imag=%h zreal=%h, want %h %h", i, dout_real, dout_imag, z_dout_real, mkr(10 + i), mki(10 + i));
            end
        end
        vectors++;
        if (empty !== 1'b1 || almost_full !== 1'b0) begin
            errors++;
            $display("FAIL wrap_empty: empty=%b af=%b, want 1 0", empty, almost_full);
        end
    endtask

    task automatic test_full_rw();
        for (int b = 0; b < D; b++) drive(1'b1, 1'b0, b);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 20 + i);
            vectors++;
            if (dout_valid !== 1'b1 || dout_real !== mkr(i) || dout_imag !== mki(i) || count !== CW'(D) || overflow !== 1'b0) begin
                errors++;
                $display("FAIL full_rw_%0d: valid=%b real=%h count=%0d ovf=%b, want 1 %h 16 0", i, dout_valid, dout_real, count, overflow, mkr(i));
            end
        end
        drive(1'b1, 1'b0, 25);
        vectors++;
        if (overflow !== 1'b1 || count !== CW'(D)) begin
            errors++;
            $display("FAIL overflow_set: ovf=%b count=%0d, want 1 16", overflow, count);
        end
        tick();
        vectors++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: ovf=%b, want 1", overflow);
        end
        for (int i = 0; i < D; i++) begin
            int p;
            p = (i < 11) ? i + 5 : 20 + (i - 11);
            drive(1'b0, 1'b1, 0);
            vectors++;
            if (dout_real !== mkr(p) || dout_imag !== mki(p)) begin
                errors++;
                $display("FAIL full_drain_%0d: real=%h imag=%h, want %h %h", i, dout_real, dout_imag, mkr(p), mki(p));
            end
        end
        vectors++;
        if (empty !== 1'b1 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL full_drain_end: empty=%b udf=%b, want 1 0", empty, underflow);
        end
    endtask

    task automatic test_empty_rw();
        drive(1'b1, 1'b1, 30);
        vectors++;
        if (dout_valid !== 1'b0 || underflow !== 1'b1 || count !== CW'(1)) begin
            errors++;
            $display("FAIL empty_rw: valid=%b udf=%b count=%0d, want 0 1 1", dout_valid, underflow, count);
        end
        drive(1'b0, 1'b1, 0);
        vectors++;
        if (dout_valid !== 1'b1 || dout_real !== mkr(30) || dout_imag !== mki(30) || count !== '0) begin
            errors++;
            $display("FAIL empty_rw_pop: valid=%b real=%h count=%0d, want 1 %h 0", dout_valid, dout_real, count, mkr(30));
        end
    endtask

    task automatic test_clear();
        for (int b = 0; b < 7; b++) drive(1'b1, 1'b0, b);
        vectors++;
        if (count !== CW'(7) || overflow !== 1'b1 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL pre_clear: count=%0d ovf=%b udf=%b, want 7 1 1", count, overflow, underflow);
        end
        clear = 1'b1;
        drive(1'b1, 1'b0, 40);
        clear = 1'b0;
        vectors++;
        if (count !== '0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_state: count=%0d empty=%b ovf=%b udf=%b, want 0 1 0 0", count, empty, overflow, underflow);
        end
        vectors++;
        if (dout_valid !== 1'b0 || dout_real !== '0 || dout_imag !== '0) begin
            errors++;
            $display("FAIL clear_dout: valid=%b real=%h imag=%h, want 0 0 0", dout_valid, dout_real, dout_imag);
        end
    endtask

    task automatic test_mid_reset();
        for (int b = 0; b < 3; b++) drive(1'b1, 1'b0, b);
        drive(1'b0, 1'b1, 0);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (count !== '0 || empty !== 1'b1 || dout_valid !== 1'b0 || dout_real !== '0) begin
            errors++;
            $display("FAIL async_reset: count=%0d empty=%b valid=%b real=%h, want 0 1 0 0", count, empty, dout_valid, dout_real);
        end
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 50);
        drive(1'b0, 1'b1, 0);
        vectors++;
        if (dout_real !== mkr(50) || count !== '0) begin
            errors++;
            $display("FAIL post_reset_pop: real=%h count=%0d, want %h 0", dout_real, count, mkr(50));
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_hold_out();
        test_wrap_af();
        test_full_rw();
        test_empty_rw();
        test_clear();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
